// File: rtl/gauss3x3_filter.sv
// 3x3 Gaussian (1-2-1 separable) blur over column-serial windows, with per-frame
// window counting, end-of-frame drain/done sequencing and a sticky partial-window flag.
module gauss3x3_filter #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ready_i,
  input  logic [DW-1:0] fifo1_data_i,
  input  logic [DW-1:0] fifo2_data_i,
  input  logic [DW-1:0] fifo3_data_i,
  input  logic          idle_i,
  input  logic          done_i,
  output logic [DW-1:0] pix_o,
  output logic          pix_valid_o,
  output logic [CW-1:0] win_count_o,
  output logic          frame_done_o,
  output logic          partial_err_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FDONE = 2'd2} state_t;

  localparam logic [DW+3:0] RND = (DW+4)'(8);

  state_t        state, state_next;
  logic [1:0]    col_cnt, col_adv;
  logic [DW+1:0] cs0, cs1, cs2, col_sum;
  logic [DW+3:0] sum, sum_rnd;
  logic          win_v, sum_v, done_q, done_rise, win_last, pending;

  assign done_rise = done_i & ~done_q;
  assign win_last  = ready_i & (col_cnt == 2'd2);
  assign col_adv   = ready_i ? (win_last ? 2'd0 : col_cnt + 2'd1) : col_cnt;
  assign col_sum   = {2'b00, fifo1_data_i} + {1'b0, fifo2_data_i, 1'b0} + {2'b00, fifo3_data_i};
  assign sum_rnd   = sum + RND;

  // A window completing on the done edge, or one still waiting for its sum or
  // its output register, belongs to the ending frame and must be drained first.
  assign pending   = win_last | win_v | sum_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt       <= 2'd0;
      cs0           <= '0;
      cs1           <= '0;
      cs2           <= '0;
      win_v         <= 1'b0;
      sum           <= '0;
      sum_v         <= 1'b0;
      pix_o         <= '0;
      pix_valid_o   <= 1'b0;
      done_q        <= 1'b0;
      partial_err_o <= 1'b0;
    end else begin
      done_q <= done_i;
      if (ready_i) begin
        case (col_cnt)
          2'd0:    cs0 <= col_sum;
          2'd1:    cs1 <= col_sum;
          default: cs2 <= col_sum;
        endcase
      end
      // The beat is accepted first; the end-of-frame check sees the advanced index.
      if (done_rise && (col_adv != 2'd0)) begin
        col_cnt       <= 2'd0;
        partial_err_o <= 1'b1;
      end else begin
        col_cnt <= col_adv;
      end
      win_v <= win_last;
      sum_v <= win_v;
      // sum is the snapshot of cs[], so a new column 0 on this edge cannot disturb it.
      if (win_v) begin
        sum <= {2'b00, cs0} + {1'b0, cs1, 1'b0} + {2'b00, cs2};
      end
      pix_valid_o <= sum_v;
      if (sum_v) begin
        pix_o <= sum_rnd[DW+3:4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_count_o <= '0;
    end else if (state == FDONE) begin
      win_count_o <= sum_v ? CW'(1) : '0;
    end else if (sum_v) begin
      win_count_o <= win_count_o + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (done_rise) begin
          state_next = pending ? DRAIN : FDONE;
        end
      end
      DRAIN: begin
        if (pix_valid_o && !win_v && !sum_v) begin
          state_next = FDONE;
        end
      end
      FDONE:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign frame_done_o = (state == FDONE);
  assign busy_o = (col_cnt != 2'd0) | win_v | sum_v | pix_valid_o | (state != RUN) | ~idle_i;

endmodule

// File: tb/tb_gauss3x3_filter.sv
// Self-checking bench for gauss3x3_filter: constant window table, hand-written frame
// sequences and random beats, all scored against a window-level reference model.
module tb_gauss3x3_filter;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ready_i;
  logic [DW-1:0] fifo1_data_i, fifo2_data_i, fifo3_data_i;
  logic          idle_i;
  logic          done_i;
  logic [DW-1:0] pix_o;
  logic          pix_valid_o;
  logic [CW-1:0] win_count_o;
  logic          frame_done_o;
  logic          partial_err_o;
  logic          busy_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gauss3x3_filter #(.DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ready_i      (ready_i),
    .fifo1_data_i (fifo1_data_i),
    .fifo2_data_i (fifo2_data_i),
    .fifo3_data_i (fifo3_data_i),
    .idle_i       (idle_i),
    .done_i       (done_i),
    .pix_o        (pix_o),
    .pix_valid_o  (pix_valid_o),
    .win_count_o  (win_count_o),
    .frame_done_o (frame_done_o),
    .partial_err_o(partial_err_o),
    .busy_o       (busy_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  // Windows are collected as whole 3x3 arrays; a finished window's blurred value
  // is queued with the edge at which it must appear on pix_o.
  int            kern[3] = '{1, 2, 1};
  int            ncol;
  int            win_px[3][3];
  logic [DW-1:0] exp_q[$];
  int            exp_due_q[$];
  int            m_cnt;
  int            fd_due;
  logic [DW-1:0] m_pix;
  logic          m_pv, m_fd, m_err, done_prev;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic rdy, input logic [DW-1:0] a, b, c,
                            input logic dn, input logic rs);
    int  acc;
    bit  frame_closed;
    if (rs) begin
      ncol = 0; exp_q.delete(); exp_due_q.delete();
      m_cnt = 0; fd_due = -1; m_pix = '0; m_pv = 1'b0; m_fd = 1'b0;
      m_err = 1'b0; done_prev = 1'b0;
      return;
    end
    m_pv = 1'b0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      m_pv  = 1'b1;
      m_pix = exp_q.pop_front();
      void'(exp_due_q.pop_front());
    end
    frame_closed = 1'b0;
    if (fd_due >= 0 && cyc == fd_due + 1) begin
      m_cnt = m_pv ? 1 : 0;
      fd_due = -1;
      frame_closed = 1'b1;
    end else if (m_pv) begin
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (rdy) begin
      win_px[ncol][0] = a; win_px[ncol][1] = b; win_px[ncol][2] = c;
      ncol++;
      if (ncol == 3) begin
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += kern[i] * kern[j] * win_px[i][j];
        exp_q.push_back(DW'((acc + 8) / 16));
        exp_due_q.push_back(cyc + 2);
        ncol = 0;
      end
    end
    if (dn && !done_prev) begin
      if (ncol != 0) begin
        m_err = 1'b1;
        ncol  = 0;
      end
      if (fd_due < 0 && !frame_closed) begin
        if (exp_due_q.size() > 0) fd_due = exp_due_q[$] + 1;
        else if (m_pv)            fd_due = cyc + 1;
        else                      fd_due = cyc;
      end
    end
    done_prev = dn;
    m_fd = (fd_due >= 0) && (cyc == fd_due);
  endtask

  task automatic compare();
    logic m_busy;
    m_busy = (ncol != 0) || (exp_q.size() > 0) || m_pv || (fd_due >= 0) || !idle_i;
    check("pix_valid",   pix_valid_o,   m_pv);
    check("pix",         pix_o,         m_pix);
    check("win_count",   win_count_o,   m_cnt);
    check("frame_done",  frame_done_o,  m_fd);
    check("partial_err", partial_err_o, m_err);
    check("busy",        busy_o,        m_busy);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rdy, input logic [DW-1:0] a, b, c,
                      input logic dn, input logic rs);
    ready_i = rdy; fifo1_data_i = a; fifo2_data_i = b; fifo3_data_i = c;
    done_i = dn; rst = rs;
    @(posedge clk);
    cyc++;
    model_edge(rdy, a, b, c, dn, rs);
    #1;
    compare();
  endtask

  task automatic beat(input logic [DW-1:0] a, b, c);
    step(1'b1, a, b, c, 1'b0, 1'b0);
  endtask

  task automatic idle_step(input logic dn);
    step(1'b0, '0, '0, '0, dn, 1'b0);
  endtask

  task automatic wait_fd(input int budget, input string name);
    int n = 0;
    while (!frame_done_o && n < budget) begin
      idle_step(1'b0);
      n++;
    end
    check(name, frame_done_o, 1);
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic [DW-1:0] px [9];
    logic [DW-1:0] exp_pix;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int pulses;
    logic [DW-1:0] a, b, c;

    rst = 1'b1; ready_i = 1'b0; done_i = 1'b0; idle_i = 1'b1;
    fifo1_data_i = '0; fifo2_data_i = '0; fifo3_data_i = '0;

    for (int v = 0; v < 7; v++)
      for (int i = 0; i < 9; i++) vecs[v].px[i] = '0;
    for (int i = 0; i < 9; i++) vecs[0].px[i] = 8'd100;
    vecs[0].exp_pix = 8'd100;
    vecs[1].px[4] = 8'd160; vecs[1].exp_pix = 8'd40;
    vecs[2].px[0] = 8'd8;   vecs[2].exp_pix = 8'd1;
    vecs[3].px[8] = 8'd7;   vecs[3].exp_pix = 8'd0;
    for (int i = 0; i < 3; i++) vecs[4].px[i] = 8'd16;
    vecs[4].exp_pix = 8'd4;
    for (int i = 0; i < 9; i++) vecs[5].px[i] = 8'd255;
    vecs[5].exp_pix = 8'd255;
    for (int r = 0; r < 3; r++) begin
      vecs[6].px[r*3+1] = 8'd128;
      vecs[6].px[r*3+2] = 8'd255;
    end
    vecs[6].exp_pix = 8'd128;

    // Reset state
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("rst_pix", pix_o, 0);
    check("rst_valid", pix_valid_o, 0);
    check("rst_count", win_count_o, 0);
    check("rst_busy", busy_o, 0);
    idle_step(1'b0);

    // Table of single windows: pixel appears two edges after the third beat
    for (int v = 0; v < 7; v++) begin
      for (int col = 0; col < 3; col++)
        beat(vecs[v].px[col], vecs[v].px[3+col], vecs[v].px[6+col]);
      idle_step(1'b0);
      check($sformatf("vec%0d_early", v), pix_valid_o, 0);
      idle_step(1'b0);
      check($sformatf("vec%0d_valid", v), pix_valid_o, 1);
      check($sformatf("vec%0d_pix", v), pix_o, vecs[v].exp_pix);
      if (v == 0) check("vec0_count", win_count_o, 1);
    end
    idle_step(1'b1);
    wait_fd(8, "table_frame_done");
    check("table_total", win_count_o, 7);
    idle_step(1'b0);
    check("table_count_clear", win_count_o, 0);

    // Back-to-back beats: one pixel every three cycles
    pulses = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 9) beat(8'd255, 8'd255, 8'd255);
      else       idle_step(1'b0);
      if (pix_valid_o) begin
        pulses++;
        check("burst_pix", pix_o, 255);
      end
    end
    check("burst_pulses", pulses, 3);
    check("burst_count", win_count_o, 3);

    // Gapped beats, then done with an empty pipeline
    for (int col = 0; col < 3; col++) begin
      beat(8'd10 * DW'(col + 1), 8'd50, 8'd90);
      if (col < 2) repeat (4) idle_step(1'b0);
    end
    idle_step(1'b0);
    idle_step(1'b0);
    check("gap_valid", pix_valid_o, 1);
    idle_step(1'b1);
    check("gap_frame_done", frame_done_o, 1);
    check("gap_total", win_count_o, 4);
    idle_step(1'b0);
    check("gap_count_clear", win_count_o, 0);
    check("gap_fd_single", frame_done_o, 0);

    // Done one cycle after the third beat drains the window first
    for (int col = 0; col < 3; col++)
      beat(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
    idle_step(1'b1);
    check("drain_no_fd", frame_done_o, 0);
    check("drain_busy", busy_o, 1);
    idle_step(1'b1);
    check("drain_valid", pix_valid_o, 1);
    check("drain_fd_wait", frame_done_o, 0);
    idle_step(1'b0);
    check("drain_frame_done", frame_done_o, 1);
    idle_step(1'b0);

    // Partial window at end of frame
    beat(8'd1, 8'd2, 8'd3);
    beat(8'd4, 8'd5, 8'd6);
    idle_step(1'b1);
    check("partial_err_set", partial_err_o, 1);
    repeat (4) idle_step(1'b0);
    check("partial_sticky", partial_err_o, 1);

    // Reset between beats 2 and 3 discards the window
    beat(8'd40, 8'd40, 8'd40);
    beat(8'd40, 8'd40, 8'd40);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    check("mid_rst_err", partial_err_o, 0);
    check("mid_rst_pix", pix_o, 0);
    check("mid_rst_busy", busy_o, 0);
    repeat (3) beat(8'd40, 8'd40, 8'd40);
    idle_step(1'b0);
    idle_step(1'b0);
    check("post_rst_pix", pix_o, 40);
    check("post_rst_count", win_count_o, 1);

    // Random beats, gaps and idle levels
    for (int i = 0; i < 600; i++) begin
      idle_i = 1'($urandom_range(0, 1));
      a = DW'($urandom_range(0, 255));
      b = DW'($urandom_range(0, 255));
      c = DW'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), a, b, c, 1'b0, 1'b0);
    end
    idle_i = 1'b1;
    idle_step(1'b1);
    wait_fd(10, "rand_frame_done");
    repeat (3) idle_step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
